// File: rtl/fft_frame_loader_if.sv
// Sample-stream and FFT-input signal bundle for fft_frame_loader.
// master: the loader side; slave: the upstream source / FFT core side.
interface fft_frame_loader_if #(
  parameter int W     = 16,
  parameter int LOG2N = 10
);
  logic                    in_valid;
  logic signed [W-1:0]     in_sample;
  logic                    in_ready;
  logic                    fft_done;
  logic                    fft_start;
  logic                    x_valid;
  logic        [LOG2N-1:0] x_index;
  logic signed [W-1:0]     x_re;
  logic signed [W-1:0]     x_im;
  logic                    overrun;

  modport master (
    input  in_valid, in_sample, fft_done,
    output in_ready, fft_start, x_valid, x_index, x_re, x_im, overrun
  );

  modport slave (
    output in_valid, in_sample, fft_done,
    input  in_ready, fft_start, x_valid, x_index, x_re, x_im, overrun
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Frame buffer feeding the 1024-point DIT FFT: fill in natural order, stream out bit-reversed.
// Optional macro FFT_LOADER_SAT_EN: store -2^(W-1) as -(2^(W-1)-1).
module fft_frame_loader #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int W     = 16
) (
  input logic               Clk,
  input logic               Reset_n,
  fft_frame_loader_if.master bus
);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] STREAM    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  logic [1:0]          state;
  logic [LOG2N-1:0]    wr_ptr;
  logic [LOG2N-1:0]    rd_ptr;
  logic [LOG2N-1:0]    rd_idx;
  logic                rd_issue;
  logic                rd_vld;
  logic signed [W-1:0] mem [N];
  logic signed [W-1:0] wr_data;
  logic signed [W-1:0] rd_data;
  logic                accept;
  logic                last_out;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_out = bus.x_valid && (bus.x_index == LAST);

`ifdef FFT_LOADER_SAT_EN
  assign wr_data = (bus.in_sample == {1'b1, {(W-1){1'b0}}}) ?
                   {1'b1, {(W-2){1'b0}}, 1'b1} : bus.in_sample;
`else
  assign wr_data = bus.in_sample;
`endif

  always_ff @(posedge Clk) begin
    if (accept)   mem[wr_ptr] <= wr_data;
    if (rd_issue) rd_data     <= mem[bitrev(rd_ptr)];
  end

  // Two-stage read pipeline (RAM register, output register); the FSM leaves
  // STREAM only once the last sample is on the outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_idx        <= '0;
      rd_issue      <= 1'b0;
      rd_vld        <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.fft_start <= 1'b0;
      bus.x_valid   <= 1'b0;
      bus.x_index   <= '0;
      bus.x_re      <= '0;
      bus.x_im      <= '0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.in_valid && !bus.in_ready) bus.overrun <= 1'b1;

      rd_vld        <= rd_issue;
      rd_idx        <= rd_ptr;
      bus.x_valid   <= rd_vld;
      bus.x_index   <= rd_idx;
      bus.x_re      <= rd_vld ? rd_data : '0;
      bus.x_im      <= '0;
      bus.fft_start <= rd_vld && (rd_idx == '0);

      case (state)
        FILL: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            wr_ptr <= wr_ptr + ONE;
            if (wr_ptr == LAST) begin
              state        <= STREAM;
              bus.in_ready <= 1'b0;
              rd_issue     <= 1'b1;
              rd_ptr       <= '0;
            end
          end
        end
        STREAM: begin
          bus.in_ready <= 1'b0;
          if (rd_issue) begin
            rd_ptr <= rd_ptr + ONE;
            if (rd_ptr == LAST) rd_issue <= 1'b0;
          end
          if (last_out) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          bus.in_ready <= 1'b0;
          if (bus.fft_done) begin
            state        <= FILL;
            bus.in_ready <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: a reference model queues each frame's
// bit-reversed output when the frame completes; a negedge monitor pops and compares.
module tb_fft_frame_loader;
  localparam int N     = 1024;
  localparam int LOG2N = 10;
  localparam int W     = 16;

  typedef struct {
    int idx;
    int re;
  } exp_t;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  exp_t expq[$];
  int   acc[$];
  exp_t e;
  bit   exp_ovr    = 1'b0;
  bit   prev_valid = 1'b0;
  int   prev_idx   = 0;
  int   cyc        = 0;
  int   last_acc_cyc = 0;
  int   re512      = 0;
  int   used;

  always #5 Clk = ~Clk;

  fft_frame_loader_if #(.W(W), .LOG2N(LOG2N)) bus ();

  fft_frame_loader #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  function automatic int stored(input int s);
`ifdef FFT_LOADER_SAT_EN
    if (s == -(1 << (W - 1))) return -((1 << (W - 1)) - 1);
`endif
    return s;
  endfunction

  // Monitor and reference model.
  always @(negedge Clk) begin
    cyc++;
    if (!Reset_n) begin
      expq.delete();
      acc.delete();
      exp_ovr    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("overrun", bus.overrun, exp_ovr);
      if (bus.x_valid) begin
        if (expq.size() == 0) check("unexpected x_valid", bus.x_valid, 0);
        else begin
          e = expq.pop_front();
          check("x_index", bus.x_index, e.idx);
          check("x_re", $signed(bus.x_re), e.re);
          check("x_im", $signed(bus.x_im), 0);
          check("fft_start", bus.fft_start, e.idx == 0);
          if (e.idx == 0)   check("start latency", cyc - last_acc_cyc, 3);
          if (e.idx == 512) re512 = $signed(bus.x_re);
        end
      end else begin
        check("fft_start idle", bus.fft_start, 0);
        check("x_re idle", $signed(bus.x_re), 0);
        if (prev_valid && prev_idx != N - 1) check("stream gap", bus.x_valid, 1);
      end
      prev_valid = bus.x_valid;
      prev_idx   = bus.x_index;
      if (bus.in_valid && !bus.in_ready) exp_ovr = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        acc.push_back(int'($signed(bus.in_sample)));
        if (acc.size() == N) begin
          for (int k = 0; k < N; k++) expq.push_back('{k, stored(acc[brev(k)])});
          acc.delete();
          last_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic signed [W-1:0] pick(input int mode, input int i);
    logic signed [W-1:0] v;
    if (mode == 0) return W'(i);
    v = W'($urandom);
    if (v == 16'sh1234) v = '0;
    if (mode == 2 && i == 1) v = 16'sh8000;
    return v;
  endfunction

  task automatic feed(input int n, input int mode, input int bubble_pct,
                      input int done_at, output int cycles);
    int i = 0;
    bit took;
    cycles = 0;
    while (i < n && cycles < 8 * N) begin
      bus.in_sample = pick(mode, i);
      bus.in_valid  = bus.in_ready && (int'($urandom_range(99)) >= bubble_pct);
      bus.fft_done  = (i == done_at);
      took = bus.in_valid;
      tick();
      cycles++;
      if (took) i++;
    end
    bus.in_valid = 1'b0;
    bus.fft_done = 1'b0;
    check("feed completes", i, n);
  endtask

  task automatic do_reset();
    Reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.fft_done = 1'b0;
    #1;
    check("rst in_ready", bus.in_ready, 0);
    check("rst x_valid", bus.x_valid, 0);
    check("rst fft_start", bus.fft_start, 0);
    check("rst x_index", bus.x_index, 0);
    check("rst x_re", $signed(bus.x_re), 0);
    check("rst x_im", $signed(bus.x_im), 0);
    check("rst overrun", bus.overrun, 0);
    tick();
    tick();
    Reset_n = 1'b1;
    check("in_ready before first edge", bus.in_ready, 0);
    tick();
    check("in_ready after release", bus.in_ready, 1);
  endtask

  task automatic wait_stream();
    int g = 0;
    while ((expq.size() != 0 || bus.x_valid) && g < 3 * N) begin
      tick();
      g++;
    end
    check("stream finished", expq.size(), 0);
  endtask

  task automatic release_frame();
    int hi = 0;
    repeat (50) begin
      tick();
      hi += int'(bus.in_ready);
    end
    check("in_ready held in WAIT_DONE", hi, 0);
    bus.fft_done = 1'b1;
    check("in_ready during done pulse", bus.in_ready, 0);
    tick();
    bus.fft_done = 1'b0;
    check("in_ready after done", bus.in_ready, 1);
  endtask

  initial begin
    int g;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.fft_done  = 1'b0;
    do_reset();

    // Frame A: ramp, contiguous
    feed(N, 0, 0, -1, used);
    check("fill cycles", used, N);
    check("in_ready after fill", bus.in_ready, 0);
    wait_stream();
    check("ramp x_re at 512", re512, 1);
    release_frame();

    // Frame B: random with bubbles, done ignored in FILL and STREAM, overrun
    feed(N, 1, 30, 300, used);
    repeat (5) tick();
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sh1234;
    bus.fft_done  = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    bus.fft_done = 1'b0;
    check("overrun set", bus.overrun, 1);
    wait_stream();
    check("overrun sticky", bus.overrun, 1);
    release_frame();

    // Frame C: most-negative sample at position 1, done held across stream end
    feed(N, 2, 10, -1, used);
    bus.fft_done = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 3 * N) begin
      tick();
      g++;
    end
    bus.fft_done = 1'b0;
    check("return to FILL", bus.in_ready, 1);
    check("stream done before FILL", expq.size(), 0);
`ifdef FFT_LOADER_SAT_EN
    check("saturated x_re at 512", re512, -32767);
`else
    check("raw x_re at 512", re512, -32768);
`endif

    // Reset mid-fill, then a full frame with reset at x_index 500
    feed(300, 1, 0, -1, used);
    do_reset();
    feed(N, 1, 0, -1, used);
    g = 0;
    while (!(bus.x_valid && bus.x_index == 10'd500) && g < 3 * N) begin
      tick();
      g++;
    end
    check("reached x_index 500", bus.x_index, 500);
    do_reset();
    feed(N, 0, 0, -1, used);
    wait_stream();
    release_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
